// File: rtl/mgt01_fwb_arbiter_pkg.sv
// Shared types and constants for the floating-point writeback path.
// Producer results, source indices and the FP register address/data shapes live here.
package mgt01_fwb_arbiter_pkg;

  localparam int N_FWB_SRC = 4;
  localparam int FWB_FLEN  = 32;
  localparam int FWB_NREG  = 32;
  localparam int FREG_AW   = 5;

  typedef logic [FREG_AW-1:0]  f_register_e;
  typedef logic [FWB_FLEN-1:0] float_t;

  typedef struct packed {
    f_register_e addr;
    float_t      data;
  } fwb_req_t;

  typedef enum logic [1:0] {
    FWB_FADD,
    FWB_FDIV,
    FWB_FLOAD,
    FWB_FMV
  } fwb_src_e;

endpackage

// File: rtl/mgt01_rr_arbiter.sv
// Round-robin arbiter with a registered search pointer.
// Grants the first requester at or above the pointer; the pointer moves past each winner.
module mgt01_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N-1:0]         req_i,
  input  logic                 en_i,
  input  logic                 update_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] scan_idx;
  logic          found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    ptr_d       = ptr_q;
    found       = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = PW'((32'(ptr_q) + k) % N);
      if (en_i && !found && req_i[scan_idx]) begin
        found                 = 1'b1;
        grant_o[scan_idx]     = 1'b1;
        grant_idx_o           = scan_idx;
      end
    end
    // Pointer only advances on a real grant so an idle cycle keeps fairness intact.
    if (found && update_i) begin
      ptr_d = (grant_idx_o == PW'(N - 1)) ? '0 : grant_idx_o + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mgt01_fwb_arbiter.sv
// FP writeback arbiter: one-entry buffer per producer, round-robin pick, registered write port.
// Also exports the set of registers with an in-flight write for issue-stage hazard checks.
module mgt01_fwb_arbiter
  import mgt01_fwb_arbiter_pkg::*;
#(
  parameter int N_SRC = N_FWB_SRC,
  parameter int FLEN  = FWB_FLEN,
  parameter int NREG  = FWB_NREG
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            clk_en_i,
  input  logic                            hold_i,
  input  logic [N_SRC-1:0]                src_valid_i,
  input  logic [N_SRC-1:0][FREG_AW-1:0]   src_addr_i,
  input  logic [N_SRC-1:0][FLEN-1:0]      src_data_i,
  output logic [N_SRC-1:0]                src_ready_o,
  output logic                            we_o,
  output logic [FREG_AW-1:0]              w_faddr_o,
  output logic [FLEN-1:0]                 wr_fdata_o,
  output logic [NREG-1:0]                 pend_mask_o,
  output logic                            busy_o
);

  logic [N_SRC-1:0]               buf_v_q, buf_v_d;
  logic [N_SRC-1:0][FREG_AW-1:0]  buf_addr_q, buf_addr_d;
  logic [N_SRC-1:0][FLEN-1:0]     buf_data_q, buf_data_d;
  logic                           stage_v_q, stage_v_d;
  logic [FREG_AW-1:0]             stage_addr_q, stage_addr_d;
  logic [FLEN-1:0]                stage_data_q, stage_data_d;

  logic [N_SRC-1:0]               grant;
  logic [$clog2(N_SRC)-1:0]       grant_idx;
  logic [N_SRC-1:0]               handshake;

  // Grant looks only at buffered state, so ready never depends on src_valid_i.
  mgt01_rr_arbiter #(
    .N (N_SRC)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (buf_v_q),
    .en_i        (clk_en_i & ~hold_i),
    .update_i    (clk_en_i),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign src_ready_o = {N_SRC{clk_en_i & rst_n_i}} & (~buf_v_q | grant);
  assign handshake   = src_valid_i & src_ready_o;

  always_comb begin
    buf_v_d      = buf_v_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    stage_v_d    = stage_v_q;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    if (clk_en_i) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (handshake[i]) begin
          buf_v_d[i]    = 1'b1;
          buf_addr_d[i] = src_addr_i[i];
          buf_data_d[i] = src_data_i[i];
        end else if (grant[i]) begin
          buf_v_d[i] = 1'b0;
        end
      end
      stage_v_d = |grant;
      if (|grant) begin
        stage_addr_d = buf_addr_q[grant_idx];
        stage_data_d = buf_data_q[grant_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      buf_v_q      <= '0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      stage_v_q    <= 1'b0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
    end else begin
      buf_v_q      <= buf_v_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      stage_v_q    <= stage_v_d;
      stage_addr_q <= stage_addr_d;
      stage_data_q <= stage_data_d;
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (buf_v_q[i]) begin
        pend_mask_o = pend_mask_o | (NREG'(1) << buf_addr_q[i]);
      end
    end
    if (stage_v_q) begin
      pend_mask_o = pend_mask_o | (NREG'(1) << stage_addr_q);
    end
  end

  assign we_o       = stage_v_q & clk_en_i;
  assign w_faddr_o  = stage_addr_q;
  assign wr_fdata_o = stage_data_q;
  assign busy_o     = (|buf_v_q) | stage_v_q;

endmodule
